// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the memory-access port and the single-port memory side of the arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              ma_req;
    logic              ma_we;
    logic [ADDR_W-1:0] ma_addr;
    logic [DATA_W-1:0] ma_wdata;
    logic              ma_gnt;
    logic              ma_valid;
    logic [DATA_W-1:0] ma_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;

    modport slave (
        input  if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, ma_gnt, ma_valid, ma_rdata,
        output mem_addr, mem_wdata, mem_we, stall_if
    );

    modport master (
        output if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, ma_gnt, ma_valid, ma_rdata,
        input  mem_addr, mem_wdata, mem_we, stall_if
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF/MA onto one single-port memory with MA priority and an IF starvation guard; grant-to-valid latency is 1 cycle.
// A loser is backpressured by a low gnt and must hold its request. Nothing is queued here.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF_RSP,
        ST_MA_RD_RSP,
        ST_MA_WR_RSP
    } state_t;

    state_t             r_state;
    logic [3:0]         r_starve;
    logic               r_if_vld;
    logic               r_ma_vld;
    logic [DATA_W-1:0]  r_if_hold;
    logic [DATA_W-1:0]  r_ma_hold;

    logic               w_starved;
    logic               w_if_gnt;
    logic               w_ma_gnt;

    // rst_n gates the grants directly so that nothing reaches memory while reset is held.
    assign w_starved = (r_starve == STARVE_LIM);
    assign w_if_gnt  = rst_n & bus.if_req & (~bus.ma_req | w_starved);
    assign w_ma_gnt  = rst_n & bus.ma_req & ~w_if_gnt;

    assign bus.if_gnt   = w_if_gnt;
    assign bus.ma_gnt   = w_ma_gnt;
    assign bus.stall_if = bus.if_req & ~w_if_gnt;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (w_if_gnt) begin
            bus.mem_addr = bus.if_addr;
        end else if (w_ma_gnt) begin
            bus.mem_addr  = bus.ma_addr;
            bus.mem_wdata = bus.ma_wdata;
            bus.mem_we    = bus.ma_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_if_vld <= 1'b0;
            r_ma_vld <= 1'b0;
        end else if (w_if_gnt) begin
            r_state  <= ST_IF_RSP;
            r_if_vld <= 1'b1;
            r_ma_vld <= 1'b0;
        end else if (w_ma_gnt) begin
            r_state  <= bus.ma_we ? ST_MA_WR_RSP : ST_MA_RD_RSP;
            r_if_vld <= 1'b0;
            r_ma_vld <= 1'b1;
        end else begin
            r_state  <= ST_IDLE;
            r_if_vld <= 1'b0;
            r_ma_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (bus.if_req && !w_if_gnt) begin
            if (!w_starved) begin
                r_starve <= r_starve + 4'd1;
            end
        end else begin
            r_starve <= '0;
        end
    end

    // Holding registers capture the word that is returned, so that rdata stays stable once valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_hold <= '0;
            r_ma_hold <= '0;
        end else begin
            if (r_state == ST_IF_RSP) begin
                r_if_hold <= bus.mem_rdata;
            end
            if (r_state == ST_MA_RD_RSP) begin
                r_ma_hold <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_valid = r_if_vld;
    assign bus.ma_valid = r_ma_vld;
    assign bus.if_rdata = (r_state == ST_IF_RSP)    ? bus.mem_rdata : r_if_hold;
    assign bus.ma_rdata = (r_state == ST_MA_RD_RSP) ? bus.mem_rdata : r_ma_hold;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. It includes a registered single-port memory model and hand-computed expectations.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    logic [15:0] mem_rd;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        mem_rd <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = mem_rd;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ir, input logic [15:0] ia, input logic mr, input logic mw,
                       input logic [15:0] maddr, input logic [15:0] md);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.ma_req   = mr;
        bus.ma_we    = mw;
        bus.ma_addr  = maddr;
        bus.ma_wdata = md;
    endtask

    initial begin
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0001] = 16'hA001;
        mem[16'h0300] = 16'h0300;
        for (int i = 0; i < 4; i++) mem[i] = 16'hA000 + 16'(i);

        // Requests are held high while in reset, to show that the grants are suppressed.
        drv(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0200, 16'h0055);
        step();
        chk_eq("rst_if_gnt",   32'(bus.if_gnt),    32'd0);
        chk_eq("rst_ma_gnt",   32'(bus.ma_gnt),    32'd0);
        chk_eq("rst_mem_we",   32'(bus.mem_we),    32'd0);
        chk_eq("rst_mem_addr", 32'(bus.mem_addr),  32'd0);
        chk_eq("rst_mem_wd",   32'(bus.mem_wdata), 32'd0);
        chk_eq("rst_if_vld",   32'(bus.if_valid),  32'd0);
        chk_eq("rst_ma_vld",   32'(bus.ma_valid),  32'd0);
        chk_eq("rst_if_rdata", 32'(bus.if_rdata),  32'd0);
        chk_eq("rst_ma_rdata", 32'(bus.ma_rdata),  32'd0);
        drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        rst_n = 1'b1;

        // IF-only read of 0xBEEF, then idle cycles with the word held.
        step();
        drv(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk_eq("if_rd_gnt",    32'(bus.if_gnt),   32'd1);
        chk_eq("if_rd_magnt",  32'(bus.ma_gnt),   32'd0);
        chk_eq("if_rd_addr",   32'(bus.mem_addr), 32'h0010);
        chk_eq("if_rd_we",     32'(bus.mem_we),   32'd0);
        chk_eq("if_rd_stall",  32'(bus.stall_if), 32'd0);
        step();
        chk_eq("if_rd_vld",    32'(bus.if_valid), 32'd1);
        chk_eq("if_rd_data",   32'(bus.if_rdata), 32'hBEEF);
        chk_eq("if_rd_mavld",  32'(bus.ma_valid), 32'd0);
        drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_eq("idle_if_vld",  32'(bus.if_valid), 32'd0);
            chk_eq("idle_if_hold", 32'(bus.if_rdata), 32'hBEEF);
            chk_eq("idle_addr",    32'(bus.mem_addr), 32'd0);
            chk_eq("idle_we",      32'(bus.mem_we),   32'd0);
        end

        // MA write followed by an MA read of the same address.
        drv(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h1234);
        #1;
        chk_eq("ma_wr_gnt",   32'(bus.ma_gnt),    32'd1);
        chk_eq("ma_wr_ifgnt", 32'(bus.if_gnt),    32'd0);
        chk_eq("ma_wr_we",    32'(bus.mem_we),    32'd1);
        chk_eq("ma_wr_addr",  32'(bus.mem_addr),  32'h0200);
        chk_eq("ma_wr_wd",    32'(bus.mem_wdata), 32'h1234);
        step();
        chk_eq("ma_wr_vld",   32'(bus.ma_valid),  32'd1);
        chk_eq("ma_wr_hold",  32'(bus.ma_rdata),  32'd0);
        drv(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h1234);
        #1;
        chk_eq("ma_rd_gnt",   32'(bus.ma_gnt),    32'd1);
        chk_eq("ma_rd_we",    32'(bus.mem_we),    32'd0);
        step();
        chk_eq("ma_rd_vld",   32'(bus.ma_valid),  32'd1);
        chk_eq("ma_rd_data",  32'(bus.ma_rdata),  32'h1234);
        drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        chk_eq("ma_idle_vld", 32'(bus.ma_valid),  32'd0);
        chk_eq("ma_idle_hld", 32'(bus.ma_rdata),  32'h1234);

        // Contention: MA wins three cycles, IF wins the fourth, and the pattern repeats.
        drv(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0300, 16'h0);
        for (int k = 1; k <= 8; k++) begin
            logic exp_if;
            exp_if = (k % 4 == 0);
            #1;
            chk_eq("cont_if_gnt", 32'(bus.if_gnt),   32'(exp_if));
            chk_eq("cont_ma_gnt", 32'(bus.ma_gnt),   32'(!exp_if));
            chk_eq("cont_stall",  32'(bus.stall_if), 32'(!exp_if));
            chk_eq("cont_we",     32'(bus.mem_we),   32'd0);
            step();
            chk_eq("cont_if_vld", 32'(bus.if_valid), 32'(exp_if));
            chk_eq("cont_ma_vld", 32'(bus.ma_valid), 32'(!exp_if));
            if (exp_if) chk_eq("cont_if_data", 32'(bus.if_rdata), 32'hA001);
            else        chk_eq("cont_ma_data", 32'(bus.ma_rdata), 32'h0300);
        end
        drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();

        // Back-to-back IF reads with one grant and one valid per cycle.
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 16'h0);
            #1;
            chk_eq("b2b_gnt",  32'(bus.if_gnt),   32'd1);
            chk_eq("b2b_addr", 32'(bus.mem_addr), 32'(i));
            step();
            chk_eq("b2b_vld",  32'(bus.if_valid), 32'd1);
            chk_eq("b2b_data", 32'(bus.if_rdata), 32'hA000 + 32'(i));
        end
        drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        chk_eq("b2b_end_vld", 32'(bus.if_valid), 32'd0);

        // Reset during an MA read grant, with the starve counter already non-zero.
        drv(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0200, 16'h0);
        #1;
        chk_eq("rmid_gnt1", 32'(bus.ma_gnt), 32'd1);
        step();
        chk_eq("rmid_vld1", 32'(bus.ma_valid), 32'd1);
        chk_eq("rmid_gnt2", 32'(bus.ma_gnt),   32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("rmid_magnt", 32'(bus.ma_gnt),   32'd0);
        chk_eq("rmid_ifgnt", 32'(bus.if_gnt),   32'd0);
        chk_eq("rmid_addr",  32'(bus.mem_addr), 32'd0);
        chk_eq("rmid_we",    32'(bus.mem_we),   32'd0);
        chk_eq("rmid_mavld", 32'(bus.ma_valid), 32'd0);
        chk_eq("rmid_madat", 32'(bus.ma_rdata), 32'd0);
        chk_eq("rmid_ifdat", 32'(bus.if_rdata), 32'd0);
        step();
        drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst_n = 1'b1;
        step();
        chk_eq("rrel_mavld", 32'(bus.ma_valid), 32'd0);
        chk_eq("rrel_ifvld", 32'(bus.if_valid), 32'd0);

        // A cleared counter makes IF wait a full three cycles again.
        drv(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0300, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk_eq("rcont_if_gnt", 32'(bus.if_gnt), 32'(k == 4));
            chk_eq("rcont_ma_gnt", 32'(bus.ma_gnt), 32'(k != 4));
            step();
        end
        drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, address width of all address ports.
REQ-002 Parameter: DATA_W, 16, data width of all data ports.
REQ-003 Parameter: STARVE_MAX, 3, consecutive lost IF cycles before IF is forced to win; legal range 1..15.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  fetch stage requests a read.
REQ-007 if_addr  in  ADDR_W  fetch read address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_valid  out  1  fetch read data valid.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 ma_req  in  1  memory-access stage requests an access.
REQ-012 ma_we  in  1  1 = write, 0 = read.
REQ-013 ma_addr  in  ADDR_W  MA address.
REQ-014 ma_wdata  in  DATA_W  MA write data.
REQ-015 ma_gnt  out  1  MA request accepted this cycle.
REQ-016 ma_valid  out  1  MA read data valid or write acknowledged.
REQ-017 ma_rdata  out  DATA_W  MA read data.
REQ-018 mem_addr  out  ADDR_W  address to single-port memory.
REQ-019 mem_wdata  out  DATA_W  write data to memory.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_rdata  in  DATA_W  memory read data; valid the cycle after the address is presented.
REQ-022 stall_if  out  1  if_req & ~if_gnt.

Function
REQ-023 The block SHALL grant at most one requester per cycle; grants are combinational from current requests and the starve counter.
REQ-024 Default priority SHALL be MA over IF.
REQ-025 Starve counter (4 bits) SHALL increment when if_req=1 and if_gnt=0, saturating at STARVE_MAX, and clear when if_gnt=1 or if_req=0.
REQ-026 When counter = STARVE_MAX and if_req=1, IF SHALL be granted even if ma_req=1.
REQ-027 Granted requester's address, write data and (MA only) ma_we SHALL drive mem_addr/mem_wdata/mem_we in the grant cycle; with no grant, mem_addr=0, mem_wdata=0, mem_we=0.
REQ-028 IF accesses SHALL never assert mem_we.
REQ-029 Response FSM states: IDLE, IF_RSP, MA_RD_RSP, MA_WR_RSP; next state set by the current cycle's grant (IF grant -> IF_RSP, MA read -> MA_RD_RSP, MA write -> MA_WR_RSP, none -> IDLE).
REQ-030 In IF_RSP: if_valid=1 and if_rdata=mem_rdata; in MA_RD_RSP: ma_valid=1 and ma_rdata=mem_rdata; in MA_WR_RSP: ma_valid=1, ma_rdata holds.
REQ-031 Latency SHALL be exactly 1 cycle grant-to-valid; a new grant SHALL be allowed in every response cycle (fully pipelined, 1 access/cycle).
REQ-032 if_rdata and ma_rdata SHALL hold the last returned word in holding registers when their valid is low.
REQ-033 A requester not granted SHALL keep request and payload stable; the block SHALL not latch ungranted requests.
REQ-034 Simultaneous request with starve counter below STARVE_MAX: MA granted, IF stalled, counter increments.

Reset
REQ-035 While rst_n=0: FSM=IDLE, starve counter=0, holding registers=0, all grant/valid outputs=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-036 Reset asserted mid-access SHALL drop the pending response; no valid SHALL assert in the first cycle after reset release.
REQ-037 Grants SHALL be suppressed while rst_n=0 regardless of requests.

Verification
REQ-038 IF-only read: if_req=1, if_addr=0x0010, memory[0x0010]=0xBEEF -> if_gnt same cycle, mem_addr=0x0010, next cycle if_valid=1, if_rdata=0xBEEF.
REQ-039 MA write then read: ma_we=1, ma_addr=0x0200, ma_wdata=0x1234, then ma_we=0 same address -> mem_we=1 in cycle 1, ma_valid in cycles 2 and 3, ma_rdata=0x1234 in cycle 3.
REQ-040 Contention: if_req and ma_req held high continuously, STARVE_MAX=3 -> MA granted 3 cycles, IF granted 4th cycle, stall_if=1 in cycles 1-3, pattern repeats.
REQ-041 Back-to-back IF reads of 0x0000..0x0003 -> one grant per cycle, four consecutive if_valid pulses in order, no bubbles.
REQ-042 Reset during MA read grant cycle -> all outputs 0 asynchronously, no ma_valid after release, counter=0.
REQ-043 No request for several cycles after a read of 0xBEEF -> mem_we=0, mem_addr=0, if_rdata holds 0xBEEF.
